// File: rtl/opb_reg_pkg.sv
// rtl/opb_reg_pkg.sv - shared widths, FSM state type and byte-enable mask helper
package opb_reg_pkg;

  localparam int OPB_DWIDTH = 32;
  localparam int OPB_AWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } opb_state_e;

  // BE[0] is the most significant byte on the big-endian OPB bus
  function automatic logic [OPB_DWIDTH-1:0] be_to_mask(input logic [0:3] be);
    logic [OPB_DWIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[31-8*b -: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/opb_reg_slice.sv
// rtl/opb_reg_slice.sv - one software register: byte merge, read-only mux, write strobe
module opb_reg_slice
  import opb_reg_pkg::*;
#(
  parameter logic                  C_RO    = 1'b0,
  parameter logic [OPB_DWIDTH-1:0] C_RESET = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [OPB_DWIDTH-1:0] wr_data,
  input  logic [OPB_DWIDTH-1:0] wr_mask,
  input  logic [OPB_DWIDTH-1:0] data_in,
  output logic [OPB_DWIDTH-1:0] data_out,
  output logic                  wr_strobe
);

  logic [OPB_DWIDTH-1:0] reg_q;
  logic                  wr_go;

  assign wr_go = wr_en && !C_RO;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q     <= C_RESET;
      wr_strobe <= 1'b0;
    end else begin
      wr_strobe <= wr_go;
      if (wr_go) begin
        reg_q <= (reg_q & ~wr_mask) | (wr_data & wr_mask);
      end
    end
  end

  assign data_out = C_RO ? data_in : reg_q;

endmodule

// File: rtl/opb_register_bank.sv
// rtl/opb_register_bank.sv - OPB slave with C_NUM_REGS byte-writable software registers
module opb_register_bank
  import opb_reg_pkg::*;
#(
  parameter logic [31:0]              C_BASEADDR  = 32'h00000000,
  parameter logic [31:0]              C_HIGHADDR  = 32'h000000FF,
  parameter int                       C_NUM_REGS  = 4,
  parameter logic [63:0]              C_RO_MASK   = 64'h0,
  parameter logic [32*C_NUM_REGS-1:0] C_RESET_VAL = '0
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:31]               OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:31]               OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:31]               Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  input  logic [32*C_NUM_REGS-1:0]  user_data_in,
  output logic [C_NUM_REGS-1:0]     user_wr_strobe
);

  localparam logic [OPB_AWIDTH-1:0] SPAN = C_HIGHADDR - C_BASEADDR;

  opb_state_e            state;
  logic [OPB_AWIDTH:0]   diff;
  logic                  hit;
  logic [29:0]           idx_q;
  logic                  rnw_q;
  logic [0:3]            be_q;
  logic [OPB_DWIDTH-1:0] data_q;
  logic [OPB_DWIDTH-1:0] wr_mask;
  logic [OPB_DWIDTH-1:0] rd_data;
  logic                  ack;
  logic                  unused_ok;

  // 33-bit subtract: the carry bit flags addresses below the base
  assign diff      = {1'b0, OPB_ABus} - {1'b0, C_BASEADDR};
  assign hit       = OPB_select && !diff[OPB_AWIDTH] && (diff[OPB_AWIDTH-1:0] <= SPAN);
  assign unused_ok = ^{OPB_seqAddr, diff[1:0]};

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      state  <= IDLE;
      idx_q  <= '0;
      rnw_q  <= 1'b0;
      be_q   <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          state  <= ACK;
          idx_q  <= diff[31:2];
          rnw_q  <= OPB_RNW;
          be_q   <= OPB_BE;
          data_q <= OPB_DBus;
        end
        ACK:     state <= HOLD;
        HOLD:    if (!OPB_select) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ack     = (state == ACK);
  assign wr_mask = be_to_mask(be_q);

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
    opb_reg_slice #(
      .C_RO    (C_RO_MASK[i]),
      .C_RESET (C_RESET_VAL[32*i +: 32])
    ) u_slice (
      .clk       (OPB_Clk),
      .rst_n     (OPB_Rst),
      .wr_en     (ack && !rnw_q && (idx_q == 30'(i))),
      .wr_data   (data_q),
      .wr_mask   (wr_mask),
      .data_in   (user_data_in[32*i +: 32]),
      .data_out  (user_data_out[32*i +: 32]),
      .wr_strobe (user_wr_strobe[i])
    );
  end

  // Indices past C_NUM_REGS fall through with zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx_q == 30'(i)) rd_data = user_data_out[32*i +: 32];
    end
  end

  assign Sl_DBus    = (ack && rnw_q) ? rd_data : '0;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank.sv
// tb/tb_opb_register_bank.sv - scoreboard bench for opb_register_bank
module tb_opb_register_bank;

  logic          OPB_Clk = 1'b0;
  logic          OPB_Rst = 1'b0;
  logic [0:31]   OPB_ABus = '0;
  logic [0:3]    OPB_BE = '0;
  logic [0:31]   OPB_DBus = '0;
  logic          OPB_RNW = 1'b0;
  logic          OPB_select = 1'b0;
  logic          OPB_seqAddr = 1'b0;
  logic [0:31]   Sl_DBus;
  logic          Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [127:0]  user_data_out;
  logic [127:0]  user_data_in = {32'hCAFE0001, 32'h22222222, 32'h11111111, 32'h33333333};
  logic [3:0]    user_wr_strobe;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_ack[$];
  int          exp_wr_idx[$];
  logic [31:0] exp_wr_val[$];

  opb_register_bank #(
    .C_BASEADDR  (32'h00000000),
    .C_HIGHADDR  (32'h000000FF),
    .C_NUM_REGS  (4),
    .C_RO_MASK   (64'h8),
    .C_RESET_VAL ({32'h0, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF})
  ) dut (
    .OPB_Clk        (OPB_Clk),
    .OPB_Rst        (OPB_Rst),
    .OPB_ABus       (OPB_ABus),
    .OPB_BE         (OPB_BE),
    .OPB_DBus       (OPB_DBus),
    .OPB_RNW        (OPB_RNW),
    .OPB_select     (OPB_select),
    .OPB_seqAddr    (OPB_seqAddr),
    .Sl_DBus        (Sl_DBus),
    .Sl_xferAck     (Sl_xferAck),
    .Sl_errAck      (Sl_errAck),
    .Sl_retry       (Sl_retry),
    .Sl_toutSup     (Sl_toutSup),
    .user_data_out  (user_data_out),
    .user_data_in   (user_data_in),
    .user_wr_strobe (user_wr_strobe)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT acks or strobes
  initial begin
    logic [31:0] e;
    int          wi;
    forever begin
      @(negedge OPB_Clk);
      check("tied_flags", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
      if (Sl_xferAck) begin
        if (exp_ack.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
        else begin
          e = exp_ack.pop_front();
          check("ack_data", Sl_DBus, e);
        end
      end else begin
        check("idle_dbus", Sl_DBus, 32'd0);
      end
      if (user_wr_strobe != 4'd0) begin
        if (exp_wr_idx.size() == 0) check("unexpected_strobe", {28'd0, user_wr_strobe}, 32'd0);
        else begin
          wi = exp_wr_idx.pop_front();
          e  = exp_wr_val.pop_front();
          check("strobe", {28'd0, user_wr_strobe}, 32'(1 << wi));
          check("wr_value", user_data_out[32*wi +: 32], e);
        end
      end
    end
  end

  // Called at #1 after a posedge; leaves the DUT idle at #1 after a posedge
  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [0:3] be,
                      input logic [31:0] data, input logic hit, input logic [31:0] rd_exp,
                      input int wr_idx, input logic [31:0] wr_exp, input int hold);
    if (hit) exp_ack.push_back(rnw ? rd_exp : 32'd0);
    if (wr_idx >= 0) begin
      exp_wr_idx.push_back(wr_idx);
      exp_wr_val.push_back(wr_exp);
    end
    OPB_ABus = addr; OPB_RNW = rnw; OPB_BE = be; OPB_DBus = data; OPB_select = 1'b1;
    @(posedge OPB_Clk); #1;
    check("ack_latency", {31'd0, Sl_xferAck}, {31'd0, hit});
    repeat (hold - 1) begin
      @(posedge OPB_Clk); #1;
    end
    OPB_select = 1'b0; OPB_DBus = '0;
    repeat ((hold == 1) ? 2 : 1) begin
      @(posedge OPB_Clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge OPB_Clk);
    #1;
    check("rst_reg0", user_data_out[31:0], 32'hFFFFFFFF);
    check("rst_reg1", user_data_out[63:32], 32'hDEADBEEF);
    check("rst_ack", {31'd0, Sl_xferAck}, 32'd0);
    OPB_Rst = 1'b1;
    @(posedge OPB_Clk); #1;
    check("rel_reg1", user_data_out[63:32], 32'hDEADBEEF);
    check("rel_reg2", user_data_out[95:64], 32'h00000000);
    check("ro_reg3", user_data_out[127:96], 32'hCAFE0001);
    check("rel_strobe", {28'd0, user_wr_strobe}, 32'd0);

    xfer(32'h08, 1'b0, 4'b1111, 32'h12345678, 1'b1, 32'h0, 2, 32'h12345678, 2);
    xfer(32'h08, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h12345678, -1, 32'h0, 2);
    xfer(32'h00, 1'b0, 4'b0100, 32'h00000000, 1'b1, 32'h0, 0, 32'hFF00FFFF, 2);
    xfer(32'h00, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hFF00FFFF, -1, 32'h0, 2);
    xfer(32'h00, 1'b0, 4'b0001, 32'h000000AB, 1'b1, 32'h0, 0, 32'hFF00FFAB, 2);
    xfer(32'h0C, 1'b0, 4'b1111, 32'h00000000, 1'b1, 32'h0, -1, 32'h0, 2);
    xfer(32'h0C, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hCAFE0001, -1, 32'h0, 2);
    xfer(32'h04, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hDEADBEEF, -1, 32'h0, 5);
    xfer(32'h10, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h00000000, -1, 32'h0, 2);
    xfer(32'hFF, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h00000000, -1, 32'h0, 2);
    xfer(32'h0B, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h12345678, -1, 32'h0, 2);
    xfer(32'h08, 1'b0, 4'b0000, 32'hFFFFFFFF, 1'b1, 32'h0, 2, 32'h12345678, 2);
    xfer(32'h100, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, -1, 32'h0, 2);
    xfer(32'h40, 1'b0, 4'b1111, 32'h55555555, 1'b1, 32'h0, -1, 32'h0, 2);
    xfer(32'h04, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hDEADBEEF, -1, 32'h0, 1);
    check("reg0_final", user_data_out[31:0], 32'hFF00FFAB);

    // Reset during the ack cycle of a write must abort it
    OPB_ABus = 32'h04; OPB_RNW = 1'b0; OPB_BE = 4'b1111; OPB_DBus = 32'hAAAAAAAA; OPB_select = 1'b1;
    @(posedge OPB_Clk); #1;
    check("pre_rst_ack", {31'd0, Sl_xferAck}, 32'd1);
    OPB_Rst = 1'b0;
    #1;
    check("rst_abort_ack", {31'd0, Sl_xferAck}, 32'd0);
    check("rst_abort_dbus", Sl_DBus, 32'd0);
    OPB_select = 1'b0;
    @(posedge OPB_Clk); #1;
    @(posedge OPB_Clk); #1;
    OPB_Rst = 1'b1;
    @(posedge OPB_Clk); #1;
    check("rst_reg1_kept", user_data_out[63:32], 32'hDEADBEEF);
    check("rst_reg2_reset", user_data_out[95:64], 32'h00000000);
    xfer(32'h04, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hDEADBEEF, -1, 32'h0, 2);

    repeat (3) @(posedge OPB_Clk);
    #1;
    check("pending_acks", exp_ack.size(), 32'd0);
    check("pending_writes", exp_wr_idx.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
